matrix_op_scheduler: RTL and testbench

//  Single-issue scheduler between the command front end and the matrix operation engines (add, mul, conv, ...).
//  It accepts one command at a time, validates its dimensions and opcode, then drives the selected engine's level start.
//  It owns the single BRAM port and routes it to the active engine only. Engine done/timeout is reported as one response beat.

---
 rtl/matrix_op_scheduler_if.sv | 28 ++
 rtl/matrix_op_scheduler.sv | 177 +++++++++++++++++
 tb/tb_matrix_op_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_scheduler_if.sv
// Command/response port of the matrix operation scheduler.
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready; the sender holds every cmd_* field stable with cmd_valid until then.
interface matrix_op_scheduler_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [4:0]            cmd_m;
  logic [4:0]            cmd_n;
  logic [ADDR_WIDTH-1:0] cmd_addr_op1;
  logic [ADDR_WIDTH-1:0] cmd_addr_op2;
  logic [ADDR_WIDTH-1:0] cmd_addr_res;
  logic                  busy;
  logic                  rsp_valid;
  logic [1:0]            rsp_err;
  logic [15:0]           rsp_cycles;

  modport master (
    output cmd_valid, cmd_op, cmd_m, cmd_n, cmd_addr_op1, cmd_addr_op2, cmd_addr_res,
    input  cmd_ready, busy, rsp_valid, rsp_err, rsp_cycles
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_m, cmd_n, cmd_addr_op1, cmd_addr_op2, cmd_addr_res,
    output cmd_ready, busy, rsp_valid, rsp_err, rsp_cycles
  );
endinterface

// File: rtl/matrix_op_scheduler.sv
// Single-issue scheduler: validates one command, runs the selected engine with a level start,
// owns the shared BRAM port and reports done/timeout as a single response beat.
module matrix_op_scheduler #(
  parameter int ELEMENT_WIDTH  = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int NUM_ENG        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             rst_n,
  matrix_op_scheduler_if.slave             cmd,
  output logic [NUM_ENG-1:0]               eng_start,
  input  logic [NUM_ENG-1:0]               eng_done,
  output logic [4:0]                       eng_dim_m,
  output logic [4:0]                       eng_dim_n,
  output logic [ADDR_WIDTH-1:0]            eng_addr_op1,
  output logic [ADDR_WIDTH-1:0]            eng_addr_op2,
  output logic [ADDR_WIDTH-1:0]            eng_addr_res,
  input  logic [NUM_ENG-1:0]               eng_rd_en,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]    eng_rd_addr,
  input  logic [NUM_ENG-1:0]               eng_wr_en,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]    eng_wr_addr,
  input  logic [NUM_ENG*ELEMENT_WIDTH-1:0] eng_wr_data,
  output logic [ELEMENT_WIDTH-1:0]         eng_rd_data,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  output logic                             mem_wr_en,
  output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0]         mem_wr_data,
  input  logic [ELEMENT_WIDTH-1:0]         mem_rd_data,
  output logic [2:0]                       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_RUN     = 3'd2,
    S_RELEASE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  rst_done_q;
  logic [2:0]            op_q;
  logic [4:0]            m_q, n_q;
  logic [ADDR_WIDTH-1:0] op1_q, op2_q, res_q;
  logic [1:0]            err_q;
  logic [15:0]           cycles_q;
  logic [15:0]           timer_q;
  logic [1:0]            rel_cnt_q;
  logic                  to_path_q;

  logic       accept;
  logic       done_sel;
  logic       timeout_hit;
  logic [1:0] chk_err;

  assign accept      = (state_q == S_IDLE) && rst_done_q && cmd.cmd_valid;
  assign timeout_hit = (timer_q == TIMEOUT_LAST);

  // Opcode is checked before dimensions, so a bad opcode always reports err 1.
  always_comb begin
    chk_err = 2'd0;
    if (int'(op_q) >= NUM_ENG)                              chk_err = 2'd1;
    else if (m_q == 5'd0 || m_q > 5'd16 || n_q == 5'd0 || n_q > 5'd16) chk_err = 2'd2;
  end

  always_comb begin
    done_sel = 1'b0;
    for (int k = 0; k < NUM_ENG; k++)
      if (int'(op_q) == k) done_sel = eng_done[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_CHECK;
      S_CHECK:   state_d = (chk_err != 2'd0) ? S_RESP : S_RUN;
      S_RUN:     if (done_sel || timeout_hit) state_d = S_RELEASE;
      // A timed-out engine gets four cycles to drop done before we give up on it.
      S_RELEASE: if (!done_sel || (to_path_q && rel_cnt_q == 2'd3)) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      op_q       <= '0;
      m_q        <= '0;
      n_q        <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      res_q      <= '0;
      err_q      <= '0;
      cycles_q   <= '0;
      timer_q    <= '0;
      rel_cnt_q  <= '0;
      to_path_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q  <= cmd.cmd_op;
          m_q   <= cmd.cmd_m;
          n_q   <= cmd.cmd_n;
          op1_q <= cmd.cmd_addr_op1;
          op2_q <= cmd.cmd_addr_op2;
          res_q <= cmd.cmd_addr_res;
        end
        S_CHECK: begin
          err_q     <= chk_err;
          cycles_q  <= '0;
          timer_q   <= '0;
          to_path_q <= 1'b0;
        end
        S_RUN: begin
          if (cycles_q != 16'hFFFF) cycles_q <= cycles_q + 16'd1;
          timer_q   <= timer_q + 16'd1;
          rel_cnt_q <= '0;
          if (done_sel) begin
            err_q <= 2'd0;
          end else if (timeout_hit) begin
            err_q     <= 2'd3;
            to_path_q <= 1'b1;
          end
        end
        S_RELEASE: rel_cnt_q <= rel_cnt_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Only the selected engine sees start, and only it reaches the BRAM, and only in S_RUN.
  always_comb begin
    eng_start   = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        if (int'(op_q) == k) begin
          eng_start[k] = 1'b1;
          mem_rd_en    = eng_rd_en[k];
          mem_rd_addr  = eng_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wr_en    = eng_wr_en[k];
          mem_wr_addr  = eng_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wr_data  = eng_wr_data[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
      end
    end
  end

  assign eng_rd_data    = mem_rd_data;
  assign eng_dim_m      = m_q;
  assign eng_dim_n      = n_q;
  assign eng_addr_op1   = op1_q;
  assign eng_addr_op2   = op2_q;
  assign eng_addr_res   = res_q;
  assign cmd.cmd_ready  = (state_q == S_IDLE) && rst_done_q;
  assign cmd.busy       = (state_q != S_IDLE);
  assign cmd.rsp_valid  = (state_q == S_RESP);
  assign cmd.rsp_err    = err_q;
  assign cmd.rsp_cycles = cycles_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Directed bench for matrix_op_scheduler: command/response flow, error codes, timeout,
// BRAM port routing and mid-run reset, with hand-computed expectations.
module tb_matrix_op_scheduler;
  localparam int EW = 16;
  localparam int AW = 10;
  localparam int NE = 4;
  localparam int TO = 100;

  logic              clk;
  logic              rst_n;
  logic [NE-1:0]     eng_start;
  logic [NE-1:0]     eng_done;
  logic [4:0]        eng_dim_m, eng_dim_n;
  logic [AW-1:0]     eng_addr_op1, eng_addr_op2, eng_addr_res;
  logic [NE-1:0]     eng_rd_en;
  logic [NE*AW-1:0]  eng_rd_addr;
  logic [NE-1:0]     eng_wr_en;
  logic [NE*AW-1:0]  eng_wr_addr;
  logic [NE*EW-1:0]  eng_wr_data;
  logic [EW-1:0]     eng_rd_data;
  logic              mem_rd_en, mem_wr_en;
  logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
  logic [EW-1:0]     mem_wr_data, mem_rd_data;
  logic [2:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  matrix_op_scheduler_if #(.ADDR_WIDTH(AW)) cmd_if ();

  matrix_op_scheduler #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_dim_m(eng_dim_m), .eng_dim_n(eng_dim_n),
    .eng_addr_op1(eng_addr_op1), .eng_addr_op2(eng_addr_op2), .eng_addr_res(eng_addr_res),
    .eng_rd_en(eng_rd_en), .eng_rd_addr(eng_rd_addr),
    .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .eng_rd_data(eng_rd_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: offer one command and hold it until accepted; returns at the negedge in S_CHECK
  task automatic issue(input string tag, input logic [2:0] op, input logic [4:0] m, input logic [4:0] n);
    int t;
    t = 0;
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_op       = op;
    cmd_if.cmd_m        = m;
    cmd_if.cmd_n        = n;
    cmd_if.cmd_addr_op1 = AW'(10'h040 + 10'(op));
    cmd_if.cmd_addr_op2 = AW'(10'h080 + 10'(op));
    cmd_if.cmd_addr_res = AW'(10'h0C0 + 10'(op));
    while (!cmd_if.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".accept"}, 32'(cmd_if.cmd_ready), 32'd1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check({tag, ".ready_low"}, 32'(cmd_if.cmd_ready), 32'd0);
  endtask

  // driver + engine model + response monitor for one whole operation
  task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] m, input logic [4:0] n,
                        input int done_after, input logic [1:0] exp_err, input int exp_cycles);
    logic [NE-1:0] mask;
    int start_cnt, beats, lat, rsp_lat, budget;
    bit stray_start, traffic, seen;
    logic [1:0]  got_err;
    logic [15:0] got_cyc;
    logic [4:0]  cap_m, cap_n;
    logic [AW-1:0] cap_op1, cap_res;
    mask = '0;
    for (int k = 0; k < NE; k++) mask[k] = (int'(op) == k);
    start_cnt = 0; beats = 0; rsp_lat = 0; stray_start = 0; traffic = 0; seen = 0;
    got_err = '0; got_cyc = '0; cap_m = '0; cap_n = '0; cap_op1 = '0; cap_res = '0;
    budget = exp_cycles + 30;
    issue(tag, op, m, n);
    lat = 1;
    for (int t = 0; t < budget; t++) begin
      if ((eng_start & ~mask) != 0) stray_start = 1;
      if ((eng_start & mask) != 0) begin
        start_cnt++;
        if (start_cnt == 1) begin
          cap_m = eng_dim_m; cap_n = eng_dim_n; cap_op1 = eng_addr_op1; cap_res = eng_addr_res;
        end
      end
      if (mem_rd_en || mem_wr_en) traffic = 1;
      if (cmd_if.rsp_valid) begin
        beats++;
        got_err = cmd_if.rsp_err;
        got_cyc = cmd_if.rsp_cycles;
        rsp_lat = lat;
        seen = 1;
      end
      if ((eng_start & mask) != 0 && start_cnt == done_after) eng_done = mask;
      else if ((eng_start & mask) == 0 && eng_done != 0) eng_done = '0;
      @(negedge clk);
      lat++;
      if (seen) break;
    end
    check({tag, ".beats"}, 32'(beats), 32'd1);
    check({tag, ".err"}, 32'(got_err), 32'(exp_err));
    check({tag, ".cycles"}, 32'(got_cyc), 32'(exp_cycles));
    check({tag, ".start_cnt"}, 32'(start_cnt), 32'(exp_cycles));
    check({tag, ".stray_start"}, 32'(stray_start), 32'd0);
    check({tag, ".traffic"}, 32'(traffic), 32'd0);
    check({tag, ".rsp_lat"}, 32'(rsp_lat), (exp_err == 2'd1 || exp_err == 2'd2) ? 32'd2 : 32'(exp_cycles + 3));
    check({tag, ".rsp_drop"}, 32'(cmd_if.rsp_valid), 32'd0);
    check({tag, ".err_hold"}, 32'(cmd_if.rsp_err), 32'(exp_err));
    check({tag, ".idle"}, {31'd0, cmd_if.busy}, 32'd0);
    if (exp_err == 2'd0 || exp_err == 2'd3) begin
      check({tag, ".dim"}, {22'd0, cap_m, cap_n}, {22'd0, m, n});
      check({tag, ".addr_op1"}, 32'(cap_op1), 32'(10'h040 + 10'(op)));
      check({tag, ".addr_res"}, 32'(cap_res), 32'(10'h0C0 + 10'(op)));
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.cmd_m = '0; cmd_if.cmd_n = '0;
    cmd_if.cmd_addr_op1 = '0; cmd_if.cmd_addr_op2 = '0; cmd_if.cmd_addr_res = '0;
    eng_done = '0; eng_rd_en = '0; eng_rd_addr = '0; eng_wr_en = '0; eng_wr_addr = '0; eng_wr_data = '0;
    mem_rd_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("rst.busy", 32'(cmd_if.busy), 32'd0);
    check("rst.rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    check("rst.eng_start", 32'(eng_start), 32'd0);
    check("rst.rsp_err", 32'(cmd_if.rsp_err), 32'd0);
    check("rst.dim_m", 32'(eng_dim_m), 32'd0);
    rst_n = 1'b1;
    #1 check("rst.ready_at_release", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("rst.ready_after", 32'(cmd_if.cmd_ready), 32'd1);

    // main function, error codes and boundaries
    run_op("t1_op2_done50", 3'd2, 5'd4, 5'd4, 50, 2'd0, 50);
    run_op("t2_bad_op", 3'd5, 5'd4, 5'd4, 0, 2'd1, 0);
    run_op("t3_m0", 3'd0, 5'd0, 5'd4, 0, 2'd2, 0);
    run_op("t3_n17", 3'd1, 5'd4, 5'd17, 0, 2'd2, 0);
    run_op("t3_op_first", 3'd7, 5'd0, 5'd17, 0, 2'd1, 0);
    run_op("dims_16x1", 3'd3, 5'd16, 5'd1, 3, 2'd0, 3);
    run_op("dims_1x16", 3'd0, 5'd1, 5'd16, 1, 2'd0, 1);
    run_op("t4_timeout", 3'd1, 5'd8, 5'd8, 0, 2'd3, TO);

    // BRAM routing: engine 1 active, engine 0 keeps requesting
    eng_rd_en = 4'b0001; eng_wr_en = 4'b0001;
    eng_rd_addr[0*AW +: AW] = 10'h03F;
    eng_wr_addr[0*AW +: AW] = 10'h3AA;
    eng_wr_data[0*EW +: EW] = 16'h1111;
    #1;
    check("t5.idle_rd_en", 32'(mem_rd_en), 32'd0);
    check("t5.idle_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("t5.idle_wr_en", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    issue("t5", 3'd1, 5'd2, 5'd3);
    t = 0;
    while (eng_start[1] !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t5.start", 32'(eng_start), 32'b0010);
    check("t5.e0_rd_ignored", 32'(mem_rd_en), 32'd0);
    check("t5.e0_wr_ignored", 32'(mem_wr_en), 32'd0);
    eng_rd_en[1] = 1'b1;
    eng_rd_addr[1*AW +: AW] = 10'h012;
    mem_rd_data = 16'hA5C3;
    #1;
    check("t5.rd_en", 32'(mem_rd_en), 32'd1);
    check("t5.rd_addr", 32'(mem_rd_addr), 32'h012);
    check("t5.rd_data_bcast", 32'(eng_rd_data), 32'hA5C3);
    @(negedge clk);
    eng_rd_en[1] = 1'b0;
    eng_wr_en[1] = 1'b1;
    eng_wr_addr[1*AW +: AW] = 10'h02A;
    eng_wr_data[1*EW +: EW] = 16'hBEEF;
    #1;
    check("t5.rd_en_off", 32'(mem_rd_en), 32'd0);
    check("t5.wr_en", 32'(mem_wr_en), 32'd1);
    check("t5.wr_addr", 32'(mem_wr_addr), 32'h02A);
    check("t5.wr_data", 32'(mem_wr_data), 32'hBEEF);
    @(negedge clk);
    eng_done[1] = 1'b1;
    t = 0;
    while (eng_start[1] !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t5.wr_gated", 32'(mem_wr_en), 32'd0);
    eng_done = '0;
    t = 0;
    while (cmd_if.rsp_valid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t5.rsp", 32'(cmd_if.rsp_valid), 32'd1);
    check("t5.err", 32'(cmd_if.rsp_err), 32'd0);
    eng_rd_en = '0; eng_wr_en = '0; eng_rd_addr = '0; eng_wr_addr = '0; eng_wr_data = '0;
    @(negedge clk);

    // reset in the middle of S_RUN
    eng_rd_en = 4'b1000;
    eng_rd_addr[3*AW +: AW] = 10'h077;
    issue("t6", 3'd3, 5'd1, 5'd1);
    repeat (3) @(negedge clk);
    check("t6.pre_start", 32'(eng_start), 32'b1000);
    check("t6.pre_rd_en", 32'(mem_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6.start", 32'(eng_start), 32'd0);
    check("t6.rd_en", 32'(mem_rd_en), 32'd0);
    check("t6.rd_addr", 32'(mem_rd_addr), 32'd0);
    check("t6.busy", 32'(cmd_if.busy), 32'd0);
    check("t6.rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    eng_rd_en = '0; eng_rd_addr = '0;
    @(negedge clk);
    run_op("t6_after", 3'd3, 5'd5, 5'd6, 7, 2'd0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
